// File: rtl/filter_frame_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | filter_frame_ctrl_if : frame memory / 3x3 filter bus for the frame ctrl  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface filter_frame_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              flt_act;
  logic [7:0]        win_1;
  logic [7:0]        win_2;
  logic [7:0]        win_3;
  logic [7:0]        win_4;
  logic [7:0]        win_5;
  logic [7:0]        win_6;
  logic [7:0]        win_7;
  logic [7:0]        win_8;
  logic [7:0]        win_9;
  logic [7:0]        flt_pixel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  start,
    output busy,
    output done,
    output rd_en,
    output rd_addr,
    input  rd_data,
    output flt_act,
    output win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9,
    input  flt_pixel,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  flt_act,
    input  win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9,
    output flt_pixel,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

`default_nettype wire

// File: rtl/filter_frame_ctrl.sv
// +--------------------------------------------------------------------------+
// | filter_frame_ctrl : raster-scans a frame into a 3x3 window for the filter|
// | and writes each filtered pixel back at its window centre.  Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module filter_frame_ctrl #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int ADDR_W   = 12,
  parameter int PIPE_LAT = 7
) (
  input  logic                clk,
  input  logic                rst,
  filter_frame_ctrl_if.master bus
);

  localparam int              c_NPIX      = IMG_W * IMG_H;
  localparam int              c_COL_W     = $clog2(IMG_W);
  localparam int              c_ROW_W     = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_NPIX - 1);
  localparam logic [ADDR_W-1:0] c_CTR_OFS   = ADDR_W'(IMG_W + 1);
  localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(IMG_W - 1);
  localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                frame_start;
  logic                pipe_busy;

  logic                rd_vld_q;
  logic [c_COL_W-1:0]  col_q;
  logic [c_ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0]   cap_addr_q;
  logic [7:0]          win_q [9];
  logic                flt_act_q;
  logic [ADDR_W-1:0]   ctr_addr_q;

  logic [7:0]          lb0_q [IMG_W];
  logic [7:0]          lb1_q [IMG_W];

  logic [PIPE_LAT-1:0] dl_vld_q;
  logic [ADDR_W-1:0]   dl_addr_q [PIPE_LAT];

  // Pipeline still holds work if a capture is pending or the delay line
  // will hold a valid entry after this edge (its last stage leaves now).
  always_comb begin
    pipe_busy = rd_vld_q | flt_act_q;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      pipe_busy = pipe_busy | dl_vld_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    frame_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_SCAN;
          rd_addr_d   = '0;
          frame_start = 1'b1;
        end
      end
      S_SCAN: begin
        if (rd_addr_q == c_LAST_ADDR) begin
          state_d   = S_DRAIN;
          rd_addr_d = '0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!pipe_busy) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Capture side: row/col track the pixel arriving on rd_data this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_q   <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      cap_addr_q <= '0;
      flt_act_q  <= 1'b0;
      ctr_addr_q <= '0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      rd_vld_q  <= (state_q == S_SCAN);
      flt_act_q <= 1'b0;
      if (frame_start) begin
        col_q      <= '0;
        row_q      <= '0;
        cap_addr_q <= '0;
      end else if (rd_vld_q) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb1_q[col_q];
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb0_q[col_q];
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= bus.rd_data;
        // Requiring col>=2 keeps the window from spanning a row boundary.
        flt_act_q  <= (row_q >= c_ROW_W'(2)) && (col_q >= c_COL_W'(2));
        ctr_addr_q <= cap_addr_q - c_CTR_OFS;
        cap_addr_q <= cap_addr_q + 1'b1;
        if (col_q == c_LAST_COL) begin
          col_q <= '0;
          row_q <= (row_q == c_LAST_ROW) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Line buffers are never cleared; windows are gated by the row counter.
  always_ff @(posedge clk) begin
    if (rd_vld_q) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= bus.rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_addr_q[i] <= '0;
      end
    end else begin
      dl_vld_q[0]  <= flt_act_q;
      dl_addr_q[0] <= ctr_addr_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_vld_q[i]  <= dl_vld_q[i-1];
        dl_addr_q[i] <= dl_addr_q[i-1];
      end
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.rd_en   = (state_q == S_SCAN);
  assign bus.rd_addr = rd_addr_q;
  assign bus.flt_act = flt_act_q;
  assign bus.win_1   = win_q[0];
  assign bus.win_2   = win_q[1];
  assign bus.win_3   = win_q[2];
  assign bus.win_4   = win_q[3];
  assign bus.win_5   = win_q[4];
  assign bus.win_6   = win_q[5];
  assign bus.win_7   = win_q[6];
  assign bus.win_8   = win_q[7];
  assign bus.win_9   = win_q[8];
  assign bus.wr_en   = dl_vld_q[PIPE_LAT-1];
  assign bus.wr_addr = dl_addr_q[PIPE_LAT-1];
  assign bus.wr_data = bus.flt_pixel;

endmodule

`default_nettype wire

// File: doc/filter_frame_ctrl.md
Name: filter_frame_ctrl

Overview:
- Sequences one image frame through the 3x3 pipelined filter datapath.
- Raster-reads source pixels from a synchronous RAM and builds the 3x3 sliding window using two line buffers.
- Drives the filter's act and sw_pixel_1..9 inputs, then tracks the filter's fixed pipeline latency so each filtered pixel (cl_pixel) is written back to a result RAM at the address of its window centre.
- Sits between the frame memories and the filter top.

Parameters:
- IMG_W, 64, image width in pixels (>=3)
- IMG_H, 64, image height in pixels (>=3)
- ADDR_W, 12, pixel address width (2^ADDR_W >= IMG_W*IMG_H)
- PIPE_LAT, 7, cycles from act sampled high by the filter to the matching cl_pixel being valid

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last write
- rd_en  out  1  source RAM read strobe
- rd_addr  out  ADDR_W  source address, raster order
- rd_data  in  8  source pixel, valid the cycle after rd_en
- flt_act  out  1  to filter act; window valid
- win_1..win_9  out  8 each  to filter sw_pixel_1..9; row-major, win_1 = top-left, win_9 = bottom-right
- flt_pixel  in  8  from filter cl_pixel
- wr_en  out  1  result RAM write strobe
- wr_addr  out  ADDR_W  result address (window centre)
- wr_data  out  8  equals flt_pixel, combinational passthrough

Behaviour:
- Reset (rst=0, async): FSM to IDLE. busy, done, rd_en, flt_act and wr_en are 0. rd_addr, wr_addr and win_1..9 are 0. Row/column counters, read-valid flag and latency delay line are cleared. Line-buffer contents are not cleared; stale data is never used because windows are gated by the row counter.
- FSM states: IDLE -> SCAN on start=1. SCAN -> DRAIN after the read of address IMG_W*IMG_H-1. DRAIN -> DONE when the read pipeline and delay line are empty. DONE -> IDLE after one cycle, with done=1 during that cycle.
- start while not in IDLE is ignored.
- SCAN timing: number cycles 1,2,... after the edge that accepts start. rd_en=1 in cycles 1..N, where N = IMG_W*IMG_H. rd_addr counts 0..N-1, one address per cycle. There is no backpressure.
- Read of address a = r*IMG_W + c issues in cycle a+1; rd_data is captured at the end of cycle a+2.
- On capture, each column shifts left. The new rightmost column is {linebuf1[c], linebuf0[c], rd_data}, top to bottom. Then linebuf1[c] takes linebuf0[c] and linebuf0[c] takes rd_data.
- The column counter wraps at IMG_W-1 and the row counter increments on that wrap.
- flt_act=1 in cycle a+3 if r>=2 and c>=2; otherwise 0. win_* are registered and valid in the same cycle.
- A window never straddles rows: columns from the previous row are not used when c<2.
- Border pixels (row/col 0 or last) produce no output and are never written.
- Latency tracking: the delay line is PIPE_LAT stages of {valid, centre address}. It is loaded with {flt_act, (r-1)*IMG_W + (c-1)}.
- wr_en/wr_addr = delay-line output. wr_en is high exactly in cycle a+3+PIPE_LAT for each valid window.
- Write count per frame is (IMG_W-2)*(IMG_H-2).
- done is asserted in cycle N+3+PIPE_LAT. busy falls in the same cycle done falls.
- Reset asserted mid-frame aborts immediately: no further rd_en or wr_en, and no done. A new start after reset processes a full frame correctly.

Test Plan:
- IMG_W=IMG_H=4, PIPE_LAT=7, mem[a]=a, filter model returns sw_pixel_5 delayed 7 cycles; start in cycle 0:
  - rd_en cycles 1..16
  - flt_act cycles 13,14,17,18
  - wr_en cycles 20,21,24,25 with wr_addr 5,6,9,10 and wr_data 5,6,9,10
  - done only in cycle 26
- Same setup, window contents: in cycle 13, win_1..9 = 0,1,2,4,5,6,8,9,10. In cycle 17, win_1..9 = 4,5,6,8,9,10,12,13,14.
- Row-wrap check: flt_act=0 in cycles 15,16 (reads of columns 0,1 of row 3). No window mixes rows 2 and 3 columns.
- start pulsed in cycles 5 and 20 during a frame -> ignored; exactly 4 writes and one done.
- rst=0 in cycle 15 mid-frame -> all outputs 0 asynchronously and no done. Restart after release -> 4 correct writes, done at the 26th cycle after the new start.
- Default 64x64: exactly 3844 wr_en pulses. Last wr_addr = 62*64+62 = 4030. done in cycle 4096+3+7 = 4106.
